clk_gate_enable_ctrl: RTL and testbench

- Generates the registered enable E for the downstream integrated clock gate (latch-on-CLK-low, AND with CLK; TE is wired to that gate separately and never passes through this block).
- Watches activity from the gated domain and software permission. Drops E after a programmable idle hold-off.
- Re-raises E on activity or a wake request, with a four-phase wake handshake.
- Keeps a saturating count of gating events for power telemetry.

---
 rtl/clk_gate_pkg.sv | 22 ++
 rtl/clk_gate_enable_ctrl_holdoff_timer.sv | 51 +++++
 rtl/clk_gate_enable_ctrl.sv | 160 ++++++++++++++++
 tb/tb_clk_gate_enable_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/clk_gate_pkg.sv
// -----------------------------------------------------------------------------
// clk_gate_pkg
//   Shared definitions for the clock-gate enable controller:
//     cg_state_t           - controller state encoding (2 bits)
//     CG_IDLE_CYCLES_DFLT  - default idle hold-off before gating
//     CG_WAKE_CYCLES_DFLT  - default wake settle time before RUN
//     CG_CNT_W_DFLT        - default width of hold-off timer and event counter
// -----------------------------------------------------------------------------
package clk_gate_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        IDLE  = 2'd1,
        GATED = 2'd2,
        WAKE  = 2'd3
    } cg_state_t;

    localparam int CG_IDLE_CYCLES_DFLT = 16;
    localparam int CG_WAKE_CYCLES_DFLT = 2;
    localparam int CG_CNT_W_DFLT       = 8;

endpackage

// File: rtl/clk_gate_enable_ctrl_holdoff_timer.sv
// -----------------------------------------------------------------------------
// cg_holdoff_timer
//   CNT_W-bit load/decrement down-counter with a zero flag. One instance is
//   shared by the idle hold-off and the wake settle phases of the controller.
//   Ports:
//     CLK      in  clock, rising edge
//     RN       in  asynchronous active-low reset (count -> 0)
//     clr      in  synchronous clear (highest priority)
//     load     in  load load_val
//     load_val in  value to load
//     dec      in  decrement (holds at zero)
//     zero     out count is zero
// -----------------------------------------------------------------------------
module cg_holdoff_timer #(
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            // Never wraps: the controller leaves the phase at zero anyway.
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/clk_gate_enable_ctrl.sv
// -----------------------------------------------------------------------------
// clk_gate_enable_ctrl
//   Produces the registered enable E for a downstream latch-based ICG. Gates
//   the clock after IDLE_CYCLES quiet cycles, re-enables on activity / wake
//   request / loss of sleep permission, and counts gating events.
//   Ports:
//     CLK         in  free-running clock
//     RN          in  asynchronous active-low reset
//     SLEEP_EN    in  software permission to gate (0 forces clock on)
//     BUSY        in  activity from the gated domain (blocks/cancels gating)
//     WAKE_REQ    in  four-phase wake request
//     WAKE_ACK    out wake acknowledge (clock guaranteed running)
//     E           out ICG enable, registered
//     GATED       out 1 while the clock is suppressed
//     CLR_STAT    in  synchronous clear of GATE_EVENTS
//     GATE_EVENTS out saturating count of gating transitions
// -----------------------------------------------------------------------------
module clk_gate_enable_ctrl
    import clk_gate_pkg::*;
#(
    parameter int IDLE_CYCLES = CG_IDLE_CYCLES_DFLT,
    parameter int WAKE_CYCLES = CG_WAKE_CYCLES_DFLT,
    parameter int CNT_W       = CG_CNT_W_DFLT
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic             SLEEP_EN,
    input  logic             BUSY,
    input  logic             WAKE_REQ,
    output logic             WAKE_ACK,
    output logic             E,
    output logic             GATED,
    input  logic             CLR_STAT,
    output logic [CNT_W-1:0] GATE_EVENTS
);

    // The timer counts down to zero inclusively, hence the minus one.
    localparam logic [CNT_W-1:0] IDLE_LOAD = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYCLES - 1);

    cg_state_t        state_q;
    cg_state_t        state_d;
    logic             e_q;
    logic             e_d;
    logic             gated_q;
    logic             gated_d;
    logic             wake_ack_q;
    logic             wake_ack_d;
    logic [CNT_W-1:0] events_q;
    logic [CNT_W-1:0] events_d;

    logic             abort;
    logic             gate_evt;
    logic             tmr_clr;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_load_val;
    logic             tmr_dec;
    logic             tmr_zero;

    cg_holdoff_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .CLK      (CLK),
        .RN       (RN),
        .clr      (tmr_clr),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    // Anything that needs the gated clock running keeps or brings it back.
    assign abort = BUSY | WAKE_REQ | ~SLEEP_EN;

    // The GATED enumerator is scoped explicitly because the GATED port
    // shadows the wildcard import inside this module.
    always_comb begin
        state_d      = state_q;
        tmr_clr      = 1'b0;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        tmr_dec      = 1'b0;
        gate_evt     = 1'b0;

        case (state_q)
            RUN: begin
                if (!abort) begin
                    state_d      = IDLE;
                    tmr_load     = 1'b1;
                    tmr_load_val = IDLE_LOAD;
                end
            end
            IDLE: begin
                // Abort is tested first so it wins over an expiring timer.
                if (abort) begin
                    state_d = RUN;
                    tmr_clr = 1'b1;
                end else if (tmr_zero) begin
                    state_d  = clk_gate_pkg::GATED;
                    gate_evt = 1'b1;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            clk_gate_pkg::GATED: begin
                if (abort) begin
                    state_d      = WAKE;
                    tmr_load     = 1'b1;
                    tmr_load_val = WAKE_LOAD;
                end
            end
            WAKE: begin
                // Inputs are deliberately ignored until RUN is reached.
                if (tmr_zero) begin
                    state_d = RUN;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase

        // Outputs are decoded from the next state so they register in step
        // with the state flop.
        e_d        = (state_d != clk_gate_pkg::GATED);
        gated_d    = (state_d == clk_gate_pkg::GATED);
        wake_ack_d = (state_d == RUN) && WAKE_REQ;

        events_d = events_q;
        if (CLR_STAT) begin
            events_d = '0;
        end else if (gate_evt && (events_q != '1)) begin
            events_d = events_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_q    <= RUN;
            e_q        <= 1'b1;
            gated_q    <= 1'b0;
            wake_ack_q <= 1'b0;
            events_q   <= '0;
        end else begin
            state_q    <= state_d;
            e_q        <= e_d;
            gated_q    <= gated_d;
            wake_ack_q <= wake_ack_d;
            events_q   <= events_d;
        end
    end

    assign E           = e_q;
    assign GATED       = gated_q;
    assign WAKE_ACK    = wake_ack_q;
    assign GATE_EVENTS = events_q;

endmodule

// File: tb/tb_clk_gate_enable_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clk_gate_enable_ctrl
//   Directed scenarios followed by random stimulus, checked against a model
//   that counts consecutive quiet samples and wake settle cycles.
// -----------------------------------------------------------------------------
module tb_clk_gate_enable_ctrl;

    localparam int IDLE_N = 4;
    localparam int WAKE_N = 2;
    localparam int CW     = 3;
    localparam int EV_MAX = (1 << CW) - 1;

    logic          CLK      = 1'b0;
    logic          RN       = 1'b0;
    logic          SLEEP_EN = 1'b0;
    logic          BUSY     = 1'b1;
    logic          WAKE_REQ = 1'b0;
    logic          CLR_STAT = 1'b0;
    logic          WAKE_ACK;
    logic          E;
    logic          GATED;
    logic [CW-1:0] GATE_EVENTS;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    bit m_gated;
    bit m_ack;
    int m_wake_left;
    int m_quiet;
    int m_events;

    clk_gate_enable_ctrl #(
        .IDLE_CYCLES (IDLE_N),
        .WAKE_CYCLES (WAKE_N),
        .CNT_W       (CW)
    ) dut (
        .CLK         (CLK),
        .RN          (RN),
        .SLEEP_EN    (SLEEP_EN),
        .BUSY        (BUSY),
        .WAKE_REQ    (WAKE_REQ),
        .WAKE_ACK    (WAKE_ACK),
        .E           (E),
        .GATED       (GATED),
        .CLR_STAT    (CLR_STAT),
        .GATE_EVENTS (GATE_EVENTS)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_gated     = 1'b0;
        m_ack       = 1'b0;
        m_wake_left = 0;
        m_quiet     = 0;
        m_events    = 0;
    endtask

    // Gating needs IDLE_N+1 consecutive quiet samples taken while the clock
    // is settled on; waking takes WAKE_N edges during which nothing counts.
    task automatic model_edge(input bit busy, input bit wreq, input bit sleep, input bit clr);
        bit a;
        a = busy | wreq | ~sleep;
        if (m_gated) begin
            if (a) begin
                m_gated     = 1'b0;
                m_wake_left = WAKE_N;
            end
        end else if (m_wake_left > 0) begin
            m_wake_left--;
        end else begin
            if (a) m_quiet = 0;
            else   m_quiet++;
            if (m_quiet == IDLE_N + 1) begin
                m_gated = 1'b1;
                m_quiet = 0;
                if (m_events < EV_MAX) m_events++;
            end
        end
        if (clr) m_events = 0;
        m_ack = !m_gated && (m_wake_left == 0) && wreq;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".E"},        int'(E),           int'(!m_gated));
        chk({tag, ".GATED"},    int'(GATED),       int'(m_gated));
        chk({tag, ".WAKE_ACK"}, int'(WAKE_ACK),    int'(m_ack));
        chk({tag, ".EVENTS"},   int'(GATE_EVENTS), m_events);
    endtask

    // One clock: drive, edge, advance model, sample 1 time unit later.
    task automatic step(input bit busy, input bit wreq, input bit sleep, input bit clr,
                        input string tag);
        BUSY     = busy;
        WAKE_REQ = wreq;
        SLEEP_EN = sleep;
        CLR_STAT = clr;
        @(posedge CLK);
        model_edge(busy, wreq, sleep, clr);
        #1;
        check_all(tag);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        RN = 1'b1;
        check_all("reset");
        chk("reset.E_const", int'(E), 1);

        // Basic gating: E stays high IDLE_N-1 edges after the first quiet
        // sample, falls on the IDLE_N-th.
        repeat (3) step(1, 0, 1, 0, "run_busy");
        step(0, 0, 1, 0, "gate_t0");
        for (int i = 1; i < IDLE_N; i++) begin
            step(0, 0, 1, 0, "gate_hold");
            chk("gate_hold.E_const", int'(E), 1);
        end
        step(0, 0, 1, 0, "gate_fall");
        chk("gate_fall.E_const", int'(E), 0);
        chk("gate_fall.GATED_const", int'(GATED), 1);
        chk("gate_fall.EVENTS_const", int'(GATE_EVENTS), 1);

        // Asynchronous reset while gated.
        #2;
        RN = 1'b0;
        #1;
        model_reset();
        chk("async_rst.E", int'(E), 1);
        chk("async_rst.GATED", int'(GATED), 0);
        chk("async_rst.WAKE_ACK", int'(WAKE_ACK), 0);
        chk("async_rst.EVENTS", int'(GATE_EVENTS), 0);
        @(posedge CLK);
        #1;
        RN = 1'b1;
        check_all("post_rst");

        // Abort on the edge where the hold-off expires: no gating.
        step(0, 0, 1, 0, "abort_t0");
        repeat (IDLE_N - 1) step(0, 0, 1, 0, "abort_hold");
        step(1, 0, 1, 0, "abort_edge");
        chk("abort_edge.E_const", int'(E), 1);
        chk("abort_edge.EVENTS_const", int'(GATE_EVENTS), 0);
        step(1, 0, 1, 0, "abort_after");

        // Wake handshake from GATED.
        repeat (IDLE_N + 1) step(0, 0, 1, 0, "wk_gate");
        chk("wk_gate.GATED_const", int'(GATED), 1);
        step(0, 1, 1, 0, "wk_req");
        chk("wk_req.E_const", int'(E), 1);
        chk("wk_req.ACK_const", int'(WAKE_ACK), 0);
        step(0, 1, 1, 0, "wk_settle");
        chk("wk_settle.ACK_const", int'(WAKE_ACK), 0);
        step(0, 1, 1, 0, "wk_run");
        chk("wk_run.ACK_const", int'(WAKE_ACK), 1);
        repeat (3) step(0, 1, 1, 0, "wk_hold");
        step(0, 0, 1, 0, "wk_drop");
        chk("wk_drop.ACK_const", int'(WAKE_ACK), 0);
        for (int i = 1; i < IDLE_N; i++) step(0, 0, 1, 0, "wk_regate_hold");
        step(0, 0, 1, 0, "wk_regate");
        chk("wk_regate.E_const", int'(E), 0);

        // Software override while gated.
        step(0, 0, 0, 0, "sw_off");
        chk("sw_off.E_const", int'(E), 1);
        for (int i = 0; i < 100; i++) begin
            step(0, 0, 0, 0, "sw_hold");
        end
        chk("sw_hold.E_const", int'(E), 1);

        // Statistics: saturate, then clear on the same edge as an increment.
        step(1, 0, 1, 1, "st_clr");
        for (int g = 0; g < 9; g++) begin
            repeat (IDLE_N + 1) step(0, 0, 1, 0, "st_gate");
            step(1, 0, 1, 0, "st_wake");
            repeat (WAKE_N) step(1, 0, 1, 0, "st_settle");
        end
        chk("st_sat.EVENTS_const", int'(GATE_EVENTS), EV_MAX);
        repeat (IDLE_N) step(0, 0, 1, 0, "st_q");
        step(0, 0, 1, 1, "st_clr_inc");
        chk("st_clr_inc.GATED_const", int'(GATED), 1);
        chk("st_clr_inc.EVENTS_const", int'(GATE_EVENTS), 0);

        // Random traffic, biased toward quiet so gating actually happens.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 31) != 0),
                 ($urandom_range(0, 63) == 0),
                 "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
